// File: rtl/gpio_ctrl_param.sv
// Parametrised GPIO controller: Wishbone register port, input synchroniser and
// per-pin edge interrupts. Define GPIO_ATOMIC_EN to add OUT_SET/OUT_CLR registers.
`timescale 1ns/1ps
module gpio_ctrl_param #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  input  logic [GPIO_WIDTH-1:0] i_gpio,
  output logic [GPIO_WIDTH-1:0] o_gpio,
  output logic [GPIO_WIDTH-1:0] oe_gpio,
  output logic                  irq
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(2'b11);
  localparam logic [ADDR_WIDTH-1:0] OFF_OUT    = ADDR_WIDTH'(5'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_OE     = ADDR_WIDTH'(5'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_IN     = ADDR_WIDTH'(5'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(5'h0C);
  localparam logic [ADDR_WIDTH-1:0] OFF_EDGE   = ADDR_WIDTH'(5'h10);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(5'h14);
`ifdef GPIO_ATOMIC_EN
  localparam logic [ADDR_WIDTH-1:0] OFF_SET    = ADDR_WIDTH'(5'h18);
  localparam logic [ADDR_WIDTH-1:0] OFF_CLR    = ADDR_WIDTH'(5'h1C);
`endif

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] widen(input logic [GPIO_WIDTH-1:0] v);
    return 32'(v);
  endfunction

  logic                  req_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [31:0]           sel_mask_s;
  logic [GPIO_WIDTH-1:0] wmask_s;
  logic [GPIO_WIDTH-1:0] wdata_s;
  logic [GPIO_WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [GPIO_WIDTH-1:0] in_s;
  logic [GPIO_WIDTH-1:0] prev_r;
  logic [GPIO_WIDTH-1:0] rise_s;
  logic [GPIO_WIDTH-1:0] fall_s;
  logic [GPIO_WIDTH-1:0] evt_s;
  logic [GPIO_WIDTH-1:0] out_r;
  logic [GPIO_WIDTH-1:0] oe_r;
  logic [GPIO_WIDTH-1:0] mask_r;
  logic [GPIO_WIDTH-1:0] edge_r;
  logic [GPIO_WIDTH-1:0] status_r;
  logic [GPIO_WIDTH-1:0] out_nxt_s;
  logic [GPIO_WIDTH-1:0] oe_nxt_s;
  logic [GPIO_WIDTH-1:0] mask_nxt_s;
  logic [GPIO_WIDTH-1:0] edge_nxt_s;
  logic [GPIO_WIDTH-1:0] clr_s;
  logic [GPIO_WIDTH-1:0] status_nxt_s;
  logic [WARM_W-1:0]     warm_r;
  logic [31:0]           rdata_s;

  // A request is only accepted while no ack is outstanding, giving one ack per two cycles.
  assign req_s      = wb_cyc & wb_stb & ~wb_ack;
  assign wr_s       = req_s & wb_we;
  assign rd_s       = req_s & ~wb_we;
  assign off_s      = wb_adr & WORD_MASK;
  assign sel_mask_s = byte_mask(wb_sel);
  assign wmask_s    = sel_mask_s[GPIO_WIDTH-1:0];
  assign wdata_s    = wb_dat_i[GPIO_WIDTH-1:0];

  assign in_s    = sync_r[SYNC_STAGES-1];
  assign rise_s  = in_s & ~prev_r;
  assign fall_s  = ~in_s & prev_r;
  assign o_gpio  = out_r;
  assign oe_gpio = oe_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= i_gpio;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Events are masked until the synchroniser has flushed its post-reset zeros.
  always_comb begin
    evt_s = '0;
    if (warm_r == '0) begin
      evt_s = (edge_r & rise_s) | (~edge_r & fall_s);
    end else begin
      evt_s = '0;
    end
  end

  always_comb begin
    out_nxt_s  = out_r;
    oe_nxt_s   = oe_r;
    mask_nxt_s = mask_r;
    edge_nxt_s = edge_r;
    clr_s      = '0;
    if (wr_s) begin
      case (off_s)
        OFF_OUT:    out_nxt_s  = (out_r & ~wmask_s) | (wdata_s & wmask_s);
        OFF_OE:     oe_nxt_s   = (oe_r & ~wmask_s) | (wdata_s & wmask_s);
        OFF_MASK:   mask_nxt_s = (mask_r & ~wmask_s) | (wdata_s & wmask_s);
        OFF_EDGE:   edge_nxt_s = (edge_r & ~wmask_s) | (wdata_s & wmask_s);
        OFF_STATUS: clr_s      = wdata_s & wmask_s;
`ifdef GPIO_ATOMIC_EN
        OFF_SET:    out_nxt_s  = out_r | (wdata_s & wmask_s);
        OFF_CLR:    out_nxt_s  = out_r & ~(wdata_s & wmask_s);
`endif
        default:    clr_s      = '0;
      endcase
    end else begin
      clr_s = '0;
    end
  end

  // A new event on a bit beats a simultaneous write-one-to-clear of that bit.
  assign status_nxt_s = (status_r & ~clr_s) | evt_s;

  always_comb begin
    rdata_s = 32'h0;
    if (rd_s) begin
      case (off_s)
        OFF_OUT:    rdata_s = widen(out_r);
        OFF_OE:     rdata_s = widen(oe_r);
        OFF_IN:     rdata_s = widen(in_s);
        OFF_MASK:   rdata_s = widen(mask_r);
        OFF_EDGE:   rdata_s = widen(edge_r);
        OFF_STATUS: rdata_s = widen(status_r);
        default:    rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_r    <= '0;
      oe_r     <= '0;
      mask_r   <= '0;
      edge_r   <= '0;
      status_r <= '0;
      prev_r   <= '0;
      warm_r   <= WARM_INIT;
      wb_ack   <= 1'b0;
      wb_dat_o <= 32'h0;
      irq      <= 1'b0;
    end else begin
      out_r    <= out_nxt_s;
      oe_r     <= oe_nxt_s;
      mask_r   <= mask_nxt_s;
      edge_r   <= edge_nxt_s;
      status_r <= status_nxt_s;
      prev_r   <= in_s;
      if (warm_r != '0) begin
        warm_r <= warm_r - WARM_ONE;
      end else begin
        warm_r <= warm_r;
      end
      wb_ack   <= req_s;
      wb_dat_o <= rdata_s;
      irq      <= |(status_r & mask_r);
    end
  end

endmodule
